// File: rtl/conv_job_sequencer_if.sv
// Word-stream input and result output handshakes of the convolution job sequencer.
interface conv_job_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHANNELS   = 1
);
  logic                   s_valid;
  logic                   s_ready;
  logic [DATA_WIDTH-1:0]  s_data;
  logic                   s_sel;
  logic                   m_valid;
  logic                   m_ready;
  logic [CHANNELS*32-1:0] m_data;
  logic                   m_err;

  // Host side: produces words, consumes results
  modport master (
    output s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data, m_err
  );

  // Sequencer side
  modport slave (
    input  s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data, m_err
  );
endinterface

// File: rtl/conv_job_sequencer.sv
// Convolution job sequencer: assembles weight/pixel banks, fires the M.A.,
// waits for all channels' accumulate-ready and returns the sums (or a timeout).
module conv_job_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned TIMEOUT     = 1024,
  localparam int unsigned TAPS       = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned N          = CHANNELS * TAPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  conv_job_sequencer_if.slave      bus,
  output logic [N*DATA_WIDTH-1:0]  multiplier_out,
  output logic [N*DATA_WIDTH-1:0]  multiplicand_out,
  output logic [TAPS-1:0]          mstart,
  input  logic [CHANNELS*32-1:0]   c_sum,
  input  logic [CHANNELS-1:0]      c_ready,
  output logic                     busy,
  output logic                     weights_loaded,
  output logic                     err_timeout,
  input  logic                     clr_err
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] p_cnt;
  logic [CW-1:0] w_idx;
  logic [TW-1:0] wait_cnt;
  logic          accept;
  logic          capture;
  logic          expire;
  logic          result_taken;

  // A full pixel bank blocks only pixel words; weights may still stream in
  assign bus.s_ready  = (state == IDLE) && !(!bus.s_sel && (p_cnt == CW'(N)));
  assign accept       = bus.s_valid && bus.s_ready;
  // A weight word arriving on a complete bank restarts the reload at index 0
  assign w_idx        = weights_loaded ? '0 : w_cnt;
  // First WAIT cycle is skipped: the M.A. still shows the stale ready then
  assign capture      = (state == WAIT) && (wait_cnt != '0) && (&c_ready);
  assign expire       = (state == WAIT) && !capture && (wait_cnt == TW'(TIMEOUT - 1));
  assign result_taken = (state == HOLD) && bus.m_ready;

  // Bank assembly: accepted words land at their counter index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multiplier_out   <= '0;
      multiplicand_out <= '0;
      w_cnt            <= '0;
      p_cnt            <= '0;
      weights_loaded   <= 1'b0;
    end else begin
      if (accept && bus.s_sel) begin
        for (int i = 0; i < int'(N); i++) begin
          if (w_idx == CW'(i)) multiplicand_out[i*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
        end
        w_cnt          <= w_idx + CW'(1);
        weights_loaded <= (w_idx == CW'(N - 1));
      end
      if (accept && !bus.s_sel) begin
        for (int i = 0; i < int'(N); i++) begin
          if (p_cnt == CW'(i)) multiplier_out[i*DATA_WIDTH +: DATA_WIDTH] <= bus.s_data;
        end
        p_cnt <= p_cnt + CW'(1);
      end
      if (result_taken) p_cnt <= '0;
    end
  end

  // Job control: fire, wait for ready or timeout, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mstart      <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_err   <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // A timeout in the same cycle overrides the clear below
      if (clr_err) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if ((p_cnt == CW'(N)) && weights_loaded) begin
            state  <= FIRE;
            mstart <= '1;
            busy   <= 1'b1;
          end
        end
        FIRE: begin
          state    <= WAIT;
          mstart   <= '0;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (capture) begin
            bus.m_data  <= c_sum;
            bus.m_err   <= 1'b0;
            bus.m_valid <= 1'b1;
            state       <= HOLD;
          end else if (expire) begin
            bus.m_data  <= '0;
            bus.m_err   <= 1'b1;
            bus.m_valid <= 1'b1;
            err_timeout <= 1'b1;
            state       <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Bench: instance A (defaults) runs table, hand-written and random jobs against
// a bank/dot-product model; instance B (2 channels, TIMEOUT=16) covers timeout,
// partial ready, clear-vs-timeout priority and reset during WAIT.
module tb_conv_job_sequencer;

  localparam int unsigned NA = 9;
  localparam int unsigned NB = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic rst_n_a, rst_n_b;
  logic clr_a, clr_b;

  conv_job_sequencer_if #(.DATA_WIDTH(32), .CHANNELS(1)) a_if ();
  conv_job_sequencer_if #(.DATA_WIDTH(32), .CHANNELS(2)) b_if ();

  logic [NA*32-1:0] mpl_a, mcd_a;
  logic [8:0]       mstart_a;
  logic [31:0]      c_sum_a;
  logic [0:0]       c_ready_a;
  logic             busy_a, wl_a, et_a;

  logic [NB*32-1:0] mpl_b, mcd_b;
  logic [8:0]       mstart_b;
  logic [63:0]      c_sum_b;
  logic [1:0]       c_ready_b;
  logic             busy_b, wl_b, et_b;

  conv_job_sequencer #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .CHANNELS(1), .TIMEOUT(1024)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(a_if),
    .multiplier_out(mpl_a), .multiplicand_out(mcd_a), .mstart(mstart_a),
    .c_sum(c_sum_a), .c_ready(c_ready_a), .busy(busy_a),
    .weights_loaded(wl_a), .err_timeout(et_a), .clr_err(clr_a)
  );

  conv_job_sequencer #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .CHANNELS(2), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(b_if),
    .multiplier_out(mpl_b), .multiplicand_out(mcd_b), .mstart(mstart_b),
    .c_sum(c_sum_b), .c_ready(c_ready_b), .busy(busy_b),
    .weights_loaded(wl_b), .err_timeout(et_b), .clr_err(clr_b)
  );

  // M.A. stand-in for A: stale ready one cycle after mstart, then low, then the dot product
  logic [1:0]  ma_cnt = 2'd0;
  logic [31:0] ma_dot;
  always @(posedge clk) begin
    if (mstart_a == 9'h1FF)  ma_cnt <= 2'd1;
    else if (ma_cnt == 2'd1) ma_cnt <= 2'd2;
    else if (ma_cnt == 2'd2) ma_cnt <= 2'd3;
  end
  always_comb begin
    ma_dot = '0;
    for (int i = 0; i < 9; i++) ma_dot = ma_dot + mcd_a[i*32 +: 32] * mpl_a[i*32 +: 32];
  end
  assign c_ready_a = (ma_cnt != 2'd2);
  assign c_sum_a   = (ma_cnt == 2'd3) ? ma_dot : 32'hDEAD_BEEF;

  // Reference model of A's banks
  logic [31:0] rw [9];
  logic [31:0] rp [9];
  int          rwc = 0;
  int          rpc = 0;
  bit          rwl = 1'b0;

  function automatic void model_acc(input bit sel, input logic [31:0] d);
    if (sel) begin
      if (rwl) begin rwl = 1'b0; rwc = 0; end
      rw[rwc] = d;
      rwc++;
      if (rwc == 9) rwl = 1'b1;
    end else begin
      rp[rpc] = d;
      rpc++;
    end
  endfunction

  function automatic logic [31:0] model_dot();
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 9; i++) acc = acc + rw[i] * rp[i];
    return acc;
  endfunction

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present one word, wait (bounded) for ready, return at the negedge after acceptance
  task automatic send(input bit to_b, input bit sel, input logic [31:0] d);
    int  n;
    logic rdy;
    n = 0;
    if (to_b) begin b_if.s_valid = 1'b1; b_if.s_sel = sel; b_if.s_data = d; end
    else      begin a_if.s_valid = 1'b1; a_if.s_sel = sel; a_if.s_data = d; end
    #1;
    rdy = to_b ? b_if.s_ready : a_if.s_ready;
    while (!rdy && n < 40) begin
      @(negedge clk); #1; n++;
      rdy = to_b ? b_if.s_ready : a_if.s_ready;
    end
    if (!rdy) chk("send_ready", rdy, 1'b1);
    @(negedge clk);
    if (to_b) b_if.s_valid = 1'b0;
    else begin a_if.s_valid = 1'b0; model_acc(sel, d); end
  endtask

  // Called right after the completing word on A: checks fire timing, result and handshake
  task automatic expect_job_a(input string tag, input logic [31:0] exp_sum, input int hold);
    logic [287:0] ew, ep;
    int n;
    for (int i = 0; i < 9; i++) begin ew[i*32 +: 32] = rw[i]; ep[i*32 +: 32] = rp[i]; end
    chk({tag, "_mstart_early"}, mstart_a, 9'h000);
    @(negedge clk);
    chk({tag, "_mstart_pulse"}, mstart_a, 9'h1FF);
    chk({tag, "_wbank"}, mcd_a, ew);
    chk({tag, "_pbank"}, mpl_a, ep);
    @(negedge clk);
    chk({tag, "_mstart_width"}, mstart_a, 9'h000);
    n = 0;
    while (!a_if.m_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_mvalid_latency"}, 288'(n), 288'(3));
    chk({tag, "_m_data"}, a_if.m_data, exp_sum);
    chk({tag, "_m_err"}, a_if.m_err, 1'b0);
    a_if.s_sel = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, a_if.m_valid, 1'b1);
      chk({tag, "_hold_data"}, a_if.m_data, exp_sum);
      chk({tag, "_hold_sready"}, a_if.s_ready, 1'b0);
      chk({tag, "_hold_busy"}, busy_a, 1'b1);
    end
    chk({tag, "_wbank_stable"}, mcd_a, ew);
    a_if.m_ready = 1'b1;
    a_if.s_sel   = 1'b0;
    @(negedge clk);
    a_if.m_ready = 1'b0;
    rpc = 0;
    chk({tag, "_post_valid"}, a_if.m_valid, 1'b0);
    chk({tag, "_post_sready"}, a_if.s_ready, 1'b1);
    chk({tag, "_post_busy"}, busy_a, 1'b0);
  endtask

  // Wait for B's mstart after its completing word; returns with n = cycles waited
  task automatic wait_mstart_b(output int n);
    n = 0;
    while (mstart_b != 9'h1FF && n < 5) begin @(negedge clk); n++; end
    chk("b_mstart_latency", 288'(n), 288'(1));
  endtask

  task automatic take_b();
    b_if.m_ready = 1'b1;
    @(negedge clk);
    b_if.m_ready = 1'b0;
    chk("b_post_valid", b_if.m_valid, 1'b0);
  endtask

  typedef struct {
    logic [31:0] w0, wstep, p0, pstep, exp_sum;
  } vec_t;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vec_t        tbl [4];
    int          n, nw, np;
    bit          sel, any_valid;
    logic [31:0] d;

    tbl[0] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd285};
    tbl[1] = '{32'd0, 32'd0, 32'h1234, 32'd7, 32'd0};
    tbl[2] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFF7};
    tbl[3] = '{32'd3, 32'd0, 32'd10, 32'd10, 32'd1350};

    rst_n_a = 1'b0; rst_n_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    a_if.s_valid = 1'b0; a_if.s_sel = 1'b0; a_if.s_data = '0; a_if.m_ready = 1'b0;
    b_if.s_valid = 1'b0; b_if.s_sel = 1'b0; b_if.s_data = '0; b_if.m_ready = 1'b0;
    c_ready_b = 2'b00; c_sum_b = '0;
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_a_zero", {mpl_a, mcd_a} == '0 && mstart_a == '0 && a_if.m_data == '0, 1'b1);
    chk("rst_a_flags", {a_if.m_valid, a_if.m_err, busy_a, wl_a, et_a}, 5'b0);
    chk("rst_a_sready", a_if.s_ready, 1'b1);
    chk("rst_b_flags", {b_if.m_valid, b_if.m_err, busy_b, wl_b, et_b, mstart_b}, 14'b0);
    chk("rst_b_sready", b_if.s_ready, 1'b1);

    // Pixels first: full pixel bank blocks pixels, not weights, and does not fire
    for (int i = 0; i < 9; i++) send(1'b0, 1'b0, 32'd2);
    repeat (3) begin
      @(negedge clk);
      chk("pixfirst_no_fire", mstart_a, 9'h000);
      chk("pixfirst_idle", busy_a, 1'b0);
    end
    a_if.s_sel = 1'b0; #1;
    chk("pixfirst_pix_blocked", a_if.s_ready, 1'b0);
    a_if.s_sel = 1'b1; #1;
    chk("pixfirst_wgt_open", a_if.s_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("pixfirst_wl_before", wl_a, 1'b0);
      send(1'b0, 1'b1, 32'(i + 1));
    end
    chk("pixfirst_wl_after", wl_a, 1'b1);
    expect_job_a("job0", 32'd90, 5);

    // Table-driven jobs, weights reloaded first each time
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) begin
        send(1'b0, 1'b1, tbl[k].w0 + 32'(i) * tbl[k].wstep);
        if (i == 0) chk("tbl_reload_clears_wl", wl_a, 1'b0);
      end
      chk("tbl_wl_set", wl_a, 1'b1);
      for (int i = 0; i < 9; i++) send(1'b0, 1'b0, tbl[k].p0 + 32'(i) * tbl[k].pstep);
      expect_job_a("tbl", tbl[k].exp_sum, k);
    end

    // Single weight word starts a reload; full pixels must wait for the rest
    send(1'b0, 1'b1, 32'd7);
    chk("reload_wl_clear", wl_a, 1'b0);
    for (int i = 0; i < 9; i++) send(1'b0, 1'b0, 32'd3);
    repeat (4) begin
      @(negedge clk);
      chk("reload_no_fire", mstart_a, 9'h000);
    end
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 32'd7);
    expect_job_a("reload", 32'd189, 1);

    // Random jobs: optional weight reload, random interleave, gaps and backpressure
    for (int j = 0; j < 20; j++) begin
      nw = (($urandom_range(0, 2) != 0) || !rwl) ? 9 : 0;
      np = 9;
      if (nw != 0) begin send(1'b0, 1'b1, $urandom); nw--; end
      while (nw > 0 || np > 0) begin
        if (nw == 0)      sel = 1'b0;
        else if (np == 0) sel = 1'b1;
        else              sel = 1'($urandom_range(0, 1));
        d = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(1'b0, sel, d);
        if (sel) nw--; else np--;
      end
      expect_job_a("rand", model_dot(), $urandom_range(0, 3));
    end

    // B: timeout with no channel ready
    c_sum_b = 64'hAAAA_5555_0F0F_F0F0;
    for (int i = 0; i < 18; i++) send(1'b1, 1'b1, 32'(i + 1));
    for (int i = 0; i < 18; i++) send(1'b1, 1'b0, 32'd1);
    wait_mstart_b(n);
    n = 0;
    while (!b_if.m_valid && n < 40) begin @(negedge clk); n++; end
    chk("b_timeout_latency", 288'(n), 288'(17));
    chk("b_timeout_err", b_if.m_err, 1'b1);
    chk("b_timeout_data", b_if.m_data, 64'd0);
    chk("b_timeout_flag", et_b, 1'b1);
    take_b();
    chk("b_flag_sticky", et_b, 1'b1);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("b_flag_cleared", et_b, 1'b0);

    // B: partial ready is not a capture
    chk("b_weights_retained", wl_b, 1'b1);
    c_ready_b = 2'b01;
    for (int i = 0; i < 18; i++) send(1'b1, 1'b0, 32'd5);
    wait_mstart_b(n);
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_valid |= b_if.m_valid;
    end
    chk("b_partial_no_capture", any_valid, 1'b0);
    chk("b_partial_busy", busy_b, 1'b1);
    c_ready_b = 2'b11;
    c_sum_b   = 64'h1234_5678_CAFE_F00D;
    @(negedge clk);
    c_ready_b = 2'b00;
    chk("b_full_capture_valid", b_if.m_valid, 1'b1);
    chk("b_full_capture_data", b_if.m_data, 64'h1234_5678_CAFE_F00D);
    chk("b_full_capture_err", b_if.m_err, 1'b0);
    take_b();

    // B: timeout wins over a same-cycle clear
    c_ready_b = 2'b10;
    for (int i = 0; i < 18; i++) send(1'b1, 1'b0, 32'd6);
    wait_mstart_b(n);
    repeat (16) @(negedge clk);
    chk("b_prio_before", {b_if.m_valid, et_b}, 2'b00);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("b_prio_valid", b_if.m_valid, 1'b1);
    chk("b_prio_flag", et_b, 1'b1);
    take_b();

    // B: reset in WAIT discards the job
    c_ready_b = 2'b01;
    for (int i = 0; i < 18; i++) send(1'b1, 1'b0, 32'd9);
    wait_mstart_b(n);
    repeat (3) @(negedge clk);
    chk("b_wait_busy", busy_b, 1'b1);
    rst_n_b = 1'b0;
    #1;
    chk("b_rst_banks", ({mpl_b, mcd_b} == '0), 1'b1);
    chk("b_rst_outs", {b_if.m_valid, b_if.m_err, busy_b, wl_b, et_b, mstart_b}, 14'b0);
    chk("b_rst_mdata", b_if.m_data, 64'd0);
    chk("b_rst_sready", b_if.s_ready, 1'b1);
    @(negedge clk);
    rst_n_b = 1'b1;
    c_ready_b = 2'b11;
    any_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_valid |= b_if.m_valid | (mstart_b != '0);
    end
    chk("b_after_rst_quiet", any_valid, 1'b0);
    chk("b_after_rst_idle", {busy_b, b_if.s_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_job_sequencer.md
# conv_job_sequencer

Host-side initiator for the convolution processor (`ma_int_32`). It accepts a stream of kernel-weight and pixel words, assembles them into the flat multiplicand/multiplier banks, and pulses the per-tap start vector. It then waits for every channel's accumulate-ready and returns the per-channel sums on a valid/ready result port. It sits between the PS-side data mover and the M.A., replacing direct BD drive of `MULTIPLY_START`, `MULTIPLIER_INPUT` and `MULTIPLICAND_INPUT`.

## Interface
- `DATA_WIDTH`, 32, width of one pixel/weight word
- `KERNEL_SIZE`, 3, kernel edge; TAPS = KERNEL_SIZE*KERNEL_SIZE
- `CHANNELS`, 1, parallel channels; N = CHANNELS*TAPS words per bank
- `TIMEOUT`, 1024, maximum WAIT cycles before abort (≥4)

Ports:
- `clk` in 1: the single clock
- `rst_n` in 1: asynchronous, active-low reset
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in DATA_WIDTH: input word handshake
- `s_sel` in 1: 1 = weight word, 0 = pixel word
- `multiplier_out` out N*DATA_WIDTH: pixel bank; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `multiplicand_out` out N*DATA_WIDTH: weight bank, same packing
- `mstart` out TAPS: start vector to the M.A.
- `c_sum` in CHANNELS*32 / `c_ready` in CHANNELS: M.A. final accumulate and ready
- `m_valid` out 1 / `m_ready` in 1 / `m_data` out CHANNELS*32: result handshake
- `m_err` out 1: qualifies `m_data`; 1 = timeout result
- `busy` out 1: state != IDLE
- `weights_loaded` out 1: weight bank complete
- `err_timeout` out 1: sticky timeout flag
- `clr_err` in 1: synchronous clear of `err_timeout`

## Operation
- Word index = ch*TAPS + tap. There are separate counters `w_cnt` and `p_cnt` (0..N).
- Accept: `s_valid && s_ready`. The word goes to the bank selected by `s_sel` at its counter, then that counter increments.
- A weight word accepted while `weights_loaded=1` clears `weights_loaded` and writes index 0, starting a reload. `weights_loaded` sets when `w_cnt` reaches N.
- `s_ready` = (state==IDLE) && !(s_sel==0 && p_cnt==N). A full pixel bank still accepts weights.
- FSM:
  - IDLE → FIRE when `p_cnt==N && weights_loaded`. This is evaluated on registered values, so it happens the cycle after the completing word.
  - FIRE (1 cycle): `mstart` = all ones. Banks are frozen.
  - WAIT: `c_ready` is ignored on the first WAIT cycle, because the M.A. drops ready the cycle after mStart. From the second WAIT cycle, `&c_ready==1` captures `c_sum` into `m_data` with `m_err=0` and moves to HOLD.
  - WAIT timeout: the WAIT counter reaching TIMEOUT-1 without capture loads `m_data=0`, `m_err=1`, sets `err_timeout`, and moves to HOLD.
  - HOLD: `m_valid=1`. On `m_ready`, clear `p_cnt` and go to IDLE. The weight bank is retained.
- Partial `c_ready`, with some channels set, is not a capture; WAIT continues.
- `clr_err` clears `err_timeout`. A timeout occurring in the same cycle as `clr_err` takes priority: the flag stays 1.
- `c_sum` is passed unsigned and unmodified; no width conversion.

## Timing
- Reset values:
  - `multiplier_out`, `multiplicand_out`, `mstart`, `m_data`, `m_valid`, `m_err`, `busy`, `weights_loaded`, `err_timeout` = 0.
  - State = IDLE, so `s_ready`=1 after reset release.
- Let the last completing word be accepted at cycle T:
  - `mstart` high exactly at T+1.
  - WAIT from T+2.
  - Earliest capture at T+3.
  - `m_valid` one cycle after the capture cycle.
- `m_data`/`m_err` are stable while `m_valid && !m_ready`. `s_ready` returns to 1 the cycle after the result handshake.
- Banks change only on accepted words in IDLE and are stable from FIRE through HOLD.
- `rst_n` low in any state clears all registers immediately: in-flight job discarded, `weights_loaded`=0, no result emitted.

## Test plan
- Single job, defaults, weights 1..9, pixels all 2, M.A. model returns the dot product 3 cycles after `mstart` → `mstart`=9'h1FF for exactly one cycle, `m_data`=90, `m_err`=0, `m_valid` one cycle after `c_ready` is seen.
- Pixels first: 9 pixel words with no weights → no `mstart`, `s_ready`=0 for further pixel words, 1 for weight words. Then 9 weights → `mstart` the cycle after the 9th weight.
- Backpressure: hold `m_ready`=0 for 5 cycles after `m_valid` → `m_data` stable, `s_ready`=0, `busy`=1. Handshake → `s_ready`=1 next cycle.
- Timeout, TIMEOUT=16, `c_ready` never set → `m_valid` with `m_err`=1, `m_data`=0, `err_timeout`=1 stays set after handshake. `clr_err` pulse clears it.
- Weight reload: after a job, send 1 weight word → `weights_loaded`=0. 9 pixels loaded → no fire until 8 more weights arrive.
- Reset during WAIT, and `CHANNELS`=2 with `c_ready`=2'b01 held for 10 cycles → reset: all outputs 0, IDLE. Partial-ready case: no capture until 2'b11.
